// File: rtl/regfile_pkg.sv
// Shared types and helpers for the RCPU register file.
package regfile_pkg;

    // Widest data word the byte-merge helper handles; W must not exceed it.
    localparam int MAXW = 64;
    localparam int MAXB = MAXW / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } regfile_state_t;

    // Replace the bytes of old_word selected by be with those of new_word.
    function automatic logic [MAXW-1:0] be_merge(input logic [MAXW-1:0] old_word,
                                                 input logic [MAXW-1:0] new_word,
                                                 input logic [MAXB-1:0] be);
        logic [MAXW-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAXB; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks every entry once after reset or a clear request.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | array usable; clr starts a new walk from entry 0
//   CLEAR | zeroing entry idx this cycle; ends after entry DEPTH-1
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    regfile_state_t state;
    logic [AW-1:0]  idx;

    // State and walk index; clr is ignored while a walk is already running.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (idx == AW'(DEPTH - 1)) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    if (clr) begin
                        state <= CLEAR;
                        idx   <= '0;
                    end
                end
            endcase
        end
    end

    assign busy    = (state == CLEAR);
    assign clr_we  = busy;
    assign clr_idx = idx;

endmodule

// File: rtl/regfile.sv
// Two-read, one-write register file with byte enables, write-first bypass,
// optional hardwired-zero register 0 and a sequential clear engine.
module regfile
    import regfile_pkg::*;
#(
    parameter int W        = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [AW-1:0]  rd_addr_a,
    output logic [W-1:0]   rd_data_a,
    input  logic [AW-1:0]  rd_addr_b,
    output logic [W-1:0]   rd_data_b,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [W-1:0]   wr_data,
    input  logic [W/8-1:0] wr_be,
    input  logic           clr,
    output logic           busy
);

    logic [W-1:0]  mem [DEPTH];
    logic          clr_we;
    logic [AW-1:0] clr_idx;
    logic          wr_ok;
    logic [W-1:0]  wr_word;
    logic [W-1:0]  nxt_a;
    logic [W-1:0]  nxt_b;

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    // A write lands only in IDLE, outside reset, and not on the edge accepting clr.
    assign wr_ok   = rst && !busy && !clr && wr_en &&
                     !((ZERO_REG != 0) && (wr_addr == '0));
    assign wr_word = W'(be_merge(MAXW'(mem[wr_addr]), MAXW'(wr_data), MAXB'(wr_be)));

    // Read values as they will be after this edge's write (write-first bypass).
    always_comb begin
        nxt_a = (wr_ok && (wr_addr == rd_addr_a)) ? wr_word : mem[rd_addr_a];
        nxt_b = (wr_ok && (wr_addr == rd_addr_b)) ? wr_word : mem[rd_addr_b];
        if ((ZERO_REG != 0) && (rd_addr_a == '0)) nxt_a = '0;
        if ((ZERO_REG != 0) && (rd_addr_b == '0)) nxt_b = '0;
    end

    // Array update: clear walk has priority; contents are not touched by reset itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (clr_we) begin
                mem[clr_idx] <= '0;
            end else if (wr_ok) begin
                mem[wr_addr] <= wr_word;
            end
        end
    end

    // Registered read ports; forced to zero in reset, during a clear and on clr acceptance.
    always_ff @(posedge clk) begin
        if (!rst || busy || clr) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_data_a <= nxt_a;
            rd_data_b <= nxt_b;
        end
    end

endmodule
